// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised oversampling UART receiver with 2-flop input
// synchroniser, 3-sample majority vote, parity/framing flags, break-safe
// recovery and a first-word-fall-through output FIFO (valid/ready).
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          rx_clk,
  input  logic                          rx_rst_n,
  input  logic                          rx_en,
  input  logic                          i_rx,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_parity_err,
  output logic                          m_frame_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_overflow,
  output logic                          rx_busy
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  localparam logic [CW-1:0] C_M1   = CW'(M - 1);
  localparam logic [CW-1:0] C_M    = CW'(M);
  localparam logic [CW-1:0] C_MP1  = CW'(M + 1);
  localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);
  localparam logic [AW:0]   F_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT
  } state_t;

  logic [1:0]           sync_q;
  logic                 rx_s;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bitidx_q, bitidx_d;
  logic                 stop_q, stop_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 maj, exp_par, ferr_now, push;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) sync_q <= 2'b11;
    else           sync_q <= {sync_q[0], i_rx};
  end

  assign rx_s     = sync_q[1];
  // Majority of the samples taken at M-1, M and the live sample at M+1.
  assign maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign exp_par  = (PARITY == 2) ? ~^sh_q : ^sh_q;
  assign ferr_now = ferr_q | ~maj;

  // Receiver state, bit timer and frame accumulators.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitidx_q <= '0;
      stop_q   <= 1'b0;
      smp_q    <= 2'b11;
      sh_q     <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      stop_q   <= stop_d;
      smp_q    <= smp_d;
      sh_q     <= sh_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  // Next-state logic; cnt wraps per bit period and clears on state change.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
    bitidx_d = bitidx_q;
    stop_d   = stop_q;
    smp_d    = smp_q;
    sh_d     = sh_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    push     = 1'b0;
    if (cnt_q == C_M1) smp_d[0] = rx_s;
    if (cnt_q == C_M)  smp_d[1] = rx_s;
    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        bitidx_d = '0;
        stop_d   = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == C_MP1 && maj) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == C_LAST) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == C_MP1) sh_d[bitidx_q] = maj;
        if (cnt_q == C_LAST) begin
          if (bitidx_q == B_LAST) begin
            bitidx_d = '0;
            state_d  = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bitidx_d = bitidx_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (cnt_q == C_MP1)  perr_d  = (maj != exp_par);
        if (cnt_q == C_LAST) state_d = S_STOP;
      end
      S_STOP: begin
        if (cnt_q == C_MP1) begin
          ferr_d = ferr_now;
          // Last stop bit: push and leave half a bit early so a
          // back-to-back start edge is not missed.
          if (stop_q == S_LAST) begin
            push    = 1'b1;
            state_d = ferr_now ? S_WAIT : S_IDLE;
            cnt_d   = '0;
          end
        end else if (cnt_q == C_LAST) begin
          stop_d = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Disabling the receiver drops any partial frame.
    if (!rx_en) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      bitidx_d = '0;
      stop_d   = 1'b0;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
      push     = 1'b0;
    end
  end

  assign rx_busy = (state_q != S_IDLE);

  // ---------------- output FIFO ----------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          full, pop, wr;
  logic [EW-1:0] head;

  assign full    = (count_q == F_FULL);
  assign m_valid = (count_q != '0);
  assign pop     = m_valid & m_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign wr      = push & (~full | pop);

  // Storage array; contents need no reset since outputs are gated by m_valid.
  always_ff @(posedge rx_clk) begin
    if (wr) mem_q[wptr_q] <= {sh_q, perr_q, ferr_now};
  end

  // Pointers, occupancy and overflow pulse.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= push & full & ~pop;
      if (wr)  wptr_q <= wptr_q + AW'(1);
      if (pop) rptr_q <= rptr_q + AW'(1);
      case ({wr, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head         = mem_q[rptr_q];
  assign m_data       = m_valid ? head[EW-1:2] : '0;
  assign m_parity_err = m_valid & head[1] & (PARITY != 0);
  assign m_frame_err  = m_valid & head[0];
  assign fifo_count   = count_q;
  assign rx_overflow  = ovf_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: frames are built from data/parity/stop rules and
// the expected FIFO entries are queued in a behavioural model; the head of
// the DUT FIFO is checked against that queue every cycle it is valid.
module tb_uart_rx_cfg;

  typedef struct packed { logic [8:0] d; logic p; logic f; } ent_t;

  logic rx_clk = 1'b0;
  logic rx_rst_n, en0, m_ready, rx0, rx1, rx2;
  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic p0, f0, v0, o0, b0, p1, f1, v1, o1, b1, p2, f2, v2, o2, b2;
  logic [2:0] c0, c1, c2;

  always #5 rx_clk = ~rx_clk;

  uart_rx_cfg u0 (.rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_en(en0), .i_rx(rx0),
    .m_data(d0), .m_parity_err(p0), .m_frame_err(f0), .m_valid(v0), .m_ready(m_ready),
    .fifo_count(c0), .rx_overflow(o0), .rx_busy(b0));
  uart_rx_cfg #(.PARITY(2)) u1 (.rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_en(1'b1),
    .i_rx(rx1), .m_data(d1), .m_parity_err(p1), .m_frame_err(f1), .m_valid(v1),
    .m_ready(1'b1), .fifo_count(c1), .rx_overflow(o1), .rx_busy(b1));
  uart_rx_cfg #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(8)) u2 (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_en(1'b1), .i_rx(rx2), .m_data(d2),
    .m_parity_err(p2), .m_frame_err(f2), .m_valid(v2), .m_ready(1'b1),
    .fifo_count(c2), .rx_overflow(o2), .rx_busy(b2));

  int checks = 0, errors = 0;
  ent_t q[$];
  logic [7:0] pop_hist[$];
  logic [9:0] last0;
  int ovf_seen = 0, ovf_exp = 0, cnt1 = 0, cnt2 = 0;
  logic [6:0] last1, last2;
  bit rand_ready = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge rx_clk);
    #2;
  endtask

  task automatic set_line(input int which, input logic v);
    case (which)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Even parity of the low db bits, by counting ones.
  function automatic logic even_par(input logic [8:0] d, input int db);
    int c = 0;
    for (int i = 0; i < db; i++) c += int'(d[i]);
    return (c % 2) == 1;
  endfunction

  // Model of the FIFO admission rule: a completed frame finding four
  // entries held (consumer stalled) is dropped and reported as overflow.
  task automatic model_push(input ent_t e);
    if (q.size() == 4) ovf_exp++;
    else q.push_back(e);
  endtask

  // Drive one frame; the expected entry for u0 is queued at the start of
  // the last stop bit, before the receiver can possibly deliver it.
  task automatic send(input int which, input int os, input int db, input logic [8:0] data,
                      input int has_par, input logic par_bit, input int nstop,
                      input logic [1:0] stop_lv, input int glitch_bit, input int abort_bit,
                      input bit push_en);
    logic [15:0] lv;
    int n, m;
    ent_t e;
    m = os / 2;
    lv = '1;
    lv[0] = 1'b0;
    for (int i = 0; i < db; i++) lv[1+i] = data[i];
    n = 1 + db;
    if (has_par != 0) begin lv[n] = par_bit; n++; end
    e.d = '0;
    for (int i = 0; i < db; i++) e.d[i] = data[i];
    e.p = (has_par != 0) ? (par_bit != even_par(data, db)) : 1'b0;
    e.f = 1'b0;
    for (int s = 0; s < nstop; s++) begin
      lv[n+s] = stop_lv[s];
      if (!stop_lv[s]) e.f = 1'b1;
    end
    n += nstop;
    for (int b = 0; b < n; b++) begin
      if (which == 0 && push_en && b == n-1) model_push(e);
      if (b == abort_bit) en0 = 1'b0;
      set_line(which, lv[b]);
      if (b == glitch_bit) begin
        tick(m + 1); set_line(which, ~lv[b]);
        tick(1);     set_line(which, lv[b]);
        tick(os - m - 2);
      end else begin
        tick(os);
      end
    end
    set_line(which, 1'b1);
  endtask

  task automatic send8(input logic [7:0] d, input logic pbit);
    send(0, 16, 8, {1'b0, d}, 1, pbit, 1, 2'b11, -1, -1, 1);
    tick(16);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (q.size() > 0 && k < 400) begin tick(1); k++; end
    chk({nm, "_drained"}, 32'(q.size()), 0);
    tick(2);
    chk({nm, "_count0"}, 32'(c0), 0);
  endtask

  initial begin
    rx_rst_n = 1'b0; en0 = 1'b1; m_ready = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;

    fork
      // Compare process: u0 head against the model, plus u1/u2 capture.
      forever begin
        @(negedge rx_clk);
        if (v0) begin
          if (q.size() == 0) chk("spurious_valid", 32'(v0), 0);
          else begin
            chk("head", {22'd0, d0, p0, f0}, {22'd0, q[0].d[7:0], q[0].p, q[0].f});
            if (m_ready) begin
              pop_hist.push_back(d0);
              last0 = {d0, p0, f0};
              void'(q.pop_front());
            end
          end
        end
        if (o0) ovf_seen++;
        if (v1) begin cnt1++; last1 = {1'b0, d1[3:0], p1, f1}; if (d1 != 8'h3C) last1[6] = 1'b1; end
        if (v2) begin cnt2++; last2 = {d2, p2, f2}; end
      end
      forever begin
        @(posedge rx_clk); #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      end
    join_none

    // Model helper pinned by hand-computed values.
    chk("par_3C", 32'(even_par(9'h03C, 8)), 0);
    chk("par_01", 32'(even_par(9'h001, 8)), 1);
    chk("par_15_5b", 32'(even_par(9'h015, 5)), 1);

    tick(3);
    chk("rst_valid", 32'(v0), 0);
    chk("rst_data", 32'(d0), 0);
    chk("rst_flags", {30'd0, p0, f0}, 0);
    chk("rst_count", 32'(c0), 0);
    chk("rst_ovf_busy", {30'd0, o0, b0}, 0);
    rx_rst_n = 1'b1;
    tick(3);

    // Clean frame and parity error.
    m_ready = 1'b1;
    send8(8'hA5, 1'b0);
    drain("clean");
    chk("clean_lit", 32'(last0), {22'd0, 8'hA5, 2'b00});
    send8(8'h3C, 1'b1);
    drain("perr");
    chk("perr_lit", 32'(last0), {22'd0, 8'h3C, 2'b10});

    // Odd-parity instance with the same line bits reports no error.
    send(1, 16, 8, 9'h03C, 1, 1'b1, 1, 2'b11, -1, -1, 0);
    tick(16);
    chk("odd_cnt", cnt1, 1);
    chk("odd_entry", 32'(last1), {25'd0, 7'b0110_000} | 32'({1'b0, 4'hC, 2'b00}));

    // Short glitch on idle line: false start, no entry.
    rx0 = 1'b0; tick(4); rx0 = 1'b1; tick(40);
    chk("glitch_busy", 32'(b0), 0);
    chk("glitch_count", 32'(c0), 0);

    // Single-cycle inverted glitch inside a data bit.
    send(0, 16, 8, 9'h0A5, 1, 1'b0, 1, 2'b11, 3, -1, 1);
    tick(16);
    drain("mid_glitch");
    chk("mid_glitch_lit", 32'(last0), {22'd0, 8'hA5, 2'b00});

    // Break: one entry with zero data and framing error, then a clean 0x55.
    model_push('{d: 9'h000, p: 1'b0, f: 1'b1});
    rx0 = 1'b0;
    tick(30 * 16);
    chk("break_wait_busy", 32'(b0), 1);
    rx0 = 1'b1;
    tick(16);
    chk("break_idle", 32'(b0), 0);
    chk("break_lit", 32'(last0), {22'd0, 8'h00, 2'b01});
    send8(8'h55, 1'b0);
    drain("after_break");
    chk("after_break_lit", 32'(last0), {22'd0, 8'h55, 2'b00});

    // Overflow: five frames into a stalled consumer.
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send8(8'(i), even_par(9'(i), 8));
    tick(20);
    chk("ovf_count", 32'(c0), 4);
    chk("ovf_pulses", ovf_seen, 1);
    chk("ovf_model", ovf_seen, ovf_exp);
    pop_hist.delete();
    m_ready = 1'b1;
    drain("ovf");
    chk("ovf_order", {pop_hist[0], pop_hist[1], pop_hist[2], pop_hist[3]}, 32'h01020304);

    // Pop coinciding with a push into a full FIFO: no overflow.
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send8(8'(8'h10 + i), even_par(9'(8'h10 + i), 8));
    chk("full_count", 32'(c0), 4);
    fork
      send(0, 16, 8, 9'h015, 1, 1'b1, 1, 2'b11, -1, -1, 0);
      begin
        tick(4 + 8 + 10 * 16);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
      end
    join
    model_push('{d: 9'h015, p: 1'b0, f: 1'b0});
    tick(16);
    chk("simul_ovf", ovf_seen, 1);
    chk("simul_count", 32'(c0), 4);
    pop_hist.delete();
    m_ready = 1'b1;
    drain("simul");
    chk("simul_last", 32'(last0), {22'd0, 8'h15, 2'b00});

    // Abort mid-data keeps earlier FIFO contents.
    m_ready = 1'b0;
    send8(8'h42, 1'b0);
    send(0, 16, 8, 9'h077, 1, 1'b0, 1, 2'b11, -1, 4, 0);
    tick(16);
    en0 = 1'b1;
    tick(4);
    chk("abort_count", 32'(c0), 1);
    chk("abort_busy", 32'(b0), 0);
    m_ready = 1'b1;
    drain("abort");
    chk("abort_lit", 32'(last0), {22'd0, 8'h42, 2'b00});

    // Variant: 5 data bits, no parity, 2 stop bits, 8x oversampling.
    send(2, 8, 5, 9'h015, 0, 1'b0, 2, 2'b11, -1, -1, 0);
    tick(8);
    chk("v5_cnt", cnt2, 1);
    chk("v5_entry", 32'(last2), {25'd0, 5'h15, 2'b00});
    send(2, 8, 5, 9'h015, 0, 1'b0, 2, 2'b01, -1, -1, 0);
    tick(8);
    chk("v5_ferr_cnt", cnt2, 2);
    chk("v5_ferr_entry", 32'(last2), {25'd0, 5'h15, 2'b01});
    chk("v5_busy", 32'(b2), 0);

    // Randomised frames with random consumer stalls.
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      logic [8:0] data;
      bit bp, bs;
      int gl;
      data = 9'($urandom_range(0, 255));
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 7) == 0);
      gl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
      send(0, 16, 8, data, 1, even_par(data, 8) ^ bp, 1, {1'b1, ~bs}, gl, -1, 1);
      tick(16 * (bs ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2))));
    end
    drain("random");
    rand_ready = 0;
    tick(1);
    m_ready = 1'b0;

    // Asynchronous reset mid-frame clears everything at once.
    send8(8'h99, 1'b0);
    chk("pre_rst_count", 32'(c0), 1);
    rx0 = 1'b0;
    tick(48);
    rx_rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(b0), 0);
    chk("rst_mid_count", 32'(c0), 0);
    chk("rst_mid_valid", 32'(v0), 0);
    q.delete();
    rx0 = 1'b1;
    tick(3);
    rx_rst_n = 1'b1;
    tick(3);
    m_ready = 1'b1;
    send8(8'h5A, 1'b0);
    drain("post_rst");
    chk("post_rst_lit", 32'(last0), {22'd0, 8'h5A, 2'b00});
    chk("final_ovf", ovf_seen, ovf_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
